sap1_controller_sequencer: RTL
==============================

Name: sap1_controller_sequencer

Overview:
- Control unit of the SAP-1 CPU. It consumes the 4-bit opcode nibble presented by the instruction register.
- A one-hot ring counter (T-states) steps fetch and execute cycles. Each state plus opcode is decoded into the 12-bit control word that drives the PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
- The IR's load and enable strobes (Li_bar, Ei_bar) originate here, closing the loop with the IR.
- A HLT opcode stops the machine.

Parameters:
T_STATES, 6, ring length. Legal range 6..8. States beyond T6 decode as NOP.
HLT_OPCODE, 4'hF, opcode that halts the machine.

Ports:
CLK  in  1  system clock; all state changes on posedge
CLR  in  1  asynchronous active-high reset
instr_in  in  4  opcode nibble from the instruction register (stable from end of T3)
Cp  out  1  PC increment (active high)
Ep  out  1  PC enable onto W bus (active high)
Lm_bar  out  1  MAR load (active low)
CE_bar  out  1  RAM enable onto W bus (active low)
Li_bar  out  1  IR load (active low)
Ei_bar  out  1  IR address-nibble enable (active low)
La_bar  out  1  accumulator load (active low)
Ea  out  1  accumulator enable (active high)
Su  out  1  ALU subtract select (1 = subtract)
Eu  out  1  ALU enable (active high)
Lb_bar  out  1  B register load (active low)
Lo_bar  out  1  output register load (active low)
t_state  out  T_STATES  one-hot ring state, bit0 = T1
halted  out  1  machine halted (registered)

Behaviour:
- Clock and reset: one clock, CLK. Reset CLR is asynchronous and active-high.
- Reset values:
  - t_state = one-hot T1; halted = 0.
  - Control word = T1 fetch word: Ep=1, Lm_bar=0, all others inactive.
  - Inactive means active-high signals = 0 and active-low signals = 1.
- Ring counter: advances one state per posedge CLK when halted = 0. Last state wraps to T1. Ring is never anything but one-hot; an illegal value (defensive) forces T1 on the next edge.
- Control word: purely combinational decode of t_state, instr_in and halted. Zero latency from state change to control outputs.
- Fetch (all opcodes):
  - T1: Ep, Lm_bar
  - T2: Cp
  - T3: CE_bar, Li_bar
- Execute, T4/T5/T6:
  - LDA (0000): T4 Ei_bar+Lm_bar; T5 CE_bar+La_bar; T6 NOP.
  - ADD (0001): T4 Ei_bar+Lm_bar; T5 CE_bar+Lb_bar; T6 Eu+La_bar with Su=0.
  - SUB (0010): same as ADD, but T6 drives Su=1.
  - OUT (1110): T4 Ea+Lo_bar; T5/T6 NOP.
  - HLT_OPCODE: T4 NOP; halted set at the posedge ending T4.
  - Any other opcode: NOP for T4..T_STATES.
- instr_in is ignored during T1–T3.
- Halt:
  - Once halted = 1, the ring freezes (t_state holds T4) and the whole control word is forced inactive, including Cp and Ep.
  - Only CLR exits halt.
- Bus exclusivity: in every state at most one of Ep, CE_bar(low), Ei_bar(low), Ea, Eu is active.
- Reset mid-instruction: CLR at any state returns immediately (asynchronously) to T1 with halted = 0. Partially executed work is abandoned.

Optional Feature:
- Macro: SAP1_SINGLE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - The ring advances only on a posedge where step = 1 and halted = 0; otherwise t_state holds.
  - The control word is unchanged while holding. Load strobes therefore repeat, which is harmless because data is identical, except Cp. Cp is gated to assert only on the cycle in which step = 1 in T2.
  - halted sets only on a stepped T4 edge.
- Undefined: no `step` port; free-running behaviour as above.

Decomposition:
- Package sap1_pkg:
  - opcode enum (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - control-word packed struct with field order Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar
  - CW_NOP constant (inactive levels)
  - T-state index constants
- Sub-module sap1_ring_counter: one-hot ring with CLK, CLR, advance enable and t_state output; owns wrap and illegal-state recovery.
- Decode stays in the top module.

Test Plan:
- CLR pulse mid-cycle, then release → t_state=6'b000001, Ep=1, Lm_bar=0, all others inactive, halted=0.
- instr_in=4'h0 (LDA), 6 clocks → T3 has CE_bar=0 and Li_bar=0; T4 has Ei_bar=0 and Lm_bar=0; T5 has CE_bar=0 and La_bar=0; T6 is NOP; wraps to T1.
- instr_in=4'h2 (SUB) → T5 has Lb_bar=0; T6 has Eu=1, Su=1, La_bar=0; with 4'h1 (ADD), T6 has Su=0.
- instr_in=4'hF → halted=1 after the T4 edge; t_state stays 6'b001000 for 20 clocks with all outputs inactive; CLR clears to T1.
- instr_in=4'h7 (undefined) → T4–T6 all inactive; next fetch proceeds normally.
- Every cycle of a random opcode stream (assertion) → at most one bus driver active and t_state one-hot; with SAP1_SINGLE_STEP_EN, step held 0 keeps t_state constant and Cp pulses exactly once per stepped T2.

Source files
------------

// File: rtl/sap1_controller_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_pkg
//  Description : Shared types and constants for the SAP-1 controller/sequencer:
//                opcode encoding, 12-bit control-word layout, inactive
//                control word and T-state bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap1_pkg;

  // Opcodes the sequencer decodes; anything else executes as NOP.
  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word, MSB first: Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_bar;
    logic ce_bar;
    logic li_bar;
    logic ei_bar;
    logic la_bar;
    logic ea;
    logic su;
    logic eu;
    logic lb_bar;
    logic lo_bar;
  } cw_t;

  // Every strobe at its inactive level: active-high low, active-low high.
  localparam cw_t CW_NOP = '{
    cp:     1'b0, ep:     1'b0, lm_bar: 1'b1, ce_bar: 1'b1,
    li_bar: 1'b1, ei_bar: 1'b1, la_bar: 1'b1, ea:     1'b0,
    su:     1'b0, eu:     1'b0, lb_bar: 1'b1, lo_bar: 1'b1
  };

  // Bit positions of each T-state inside the one-hot ring (bit0 = T1).
  localparam int unsigned T1_IDX = 0;
  localparam int unsigned T2_IDX = 1;
  localparam int unsigned T3_IDX = 2;
  localparam int unsigned T4_IDX = 3;
  localparam int unsigned T5_IDX = 4;
  localparam int unsigned T6_IDX = 5;

endpackage : sap1_pkg
`default_nettype wire

// File: rtl/sap1_controller_sequencer_ring.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_ring_counter
//  Description : One-hot T-state ring. Advances on enabled clock edges, wraps
//                from the last state to T1, and forces T1 whenever the
//                register is found not to be one-hot.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap1_ring_counter #(
  parameter int unsigned T_STATES = 6
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                adv_i,
  output logic [T_STATES-1:0] t_state_o
);

  localparam logic [T_STATES-1:0] C_T1_ONEHOT = {{(T_STATES-1){1'b0}}, 1'b1};

  logic [T_STATES-1:0] ring_q;
  logic [T_STATES-1:0] ring_d;
  logic                legal;

  // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    legal  = (ring_q != '0) && ((ring_q & (ring_q - C_T1_ONEHOT)) == '0);
    ring_d = ring_q;
    if (!legal) begin
      ring_d = C_T1_ONEHOT;
    end else if (adv_i) begin
      ring_d = {ring_q[T_STATES-2:0], ring_q[T_STATES-1]};
    end
  end

  // Ring register, asynchronously returned to T1.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ring_q <= C_T1_ONEHOT;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign t_state_o = ring_q;

endmodule : sap1_ring_counter
`default_nettype wire

// File: rtl/sap1_controller_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_controller_sequencer
//  Description : SAP-1 control unit. Steps a one-hot T-state ring and decodes
//                state + opcode into the 12-bit control word; HLT freezes the
//                ring in T4 with all strobes inactive until CLR.
//  Optional    : SAP1_SINGLE_STEP_EN adds a 'step' input; the ring then only
//                advances on edges where step = 1, and Cp is gated by step.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int unsigned T_STATES   = 6,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [3:0]          instr_in,
`ifdef SAP1_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                Cp,
  output logic                Ep,
  output logic                Lm_bar,
  output logic                CE_bar,
  output logic                Li_bar,
  output logic                Ei_bar,
  output logic                La_bar,
  output logic                Ea,
  output logic                Su,
  output logic                Eu,
  output logic                Lb_bar,
  output logic                Lo_bar,
  output logic [T_STATES-1:0] t_state,
  output logic                halted
);

  logic                halted_q;
  logic                halted_d;
  logic                step_en;
  logic                halt_now;
  logic                ring_adv;
  logic [T_STATES-1:0] ring_state;
  cw_t                 cw;

`ifdef SAP1_SINGLE_STEP_EN
  assign step_en = step;
`else
  assign step_en = 1'b1;
`endif

  // A HLT in T4 halts on this edge and keeps the ring parked in T4.
  always_comb begin
    halt_now = step_en && !halted_q && ring_state[T4_IDX] && (instr_in == HLT_OPCODE);
    ring_adv = step_en && !halted_q && !halt_now;
    halted_d = halted_q || halt_now;
  end

  sap1_ring_counter #(
    .T_STATES (T_STATES)
  ) u_ring (
    .CLK       (CLK),
    .CLR       (CLR),
    .adv_i     (ring_adv),
    .t_state_o (ring_state)
  );

  // Halt flag; only CLR leaves the halted state.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Control-word decode: fetch in T1..T3, opcode-specific execute in T4..T6.
  always_comb begin
    cw = CW_NOP;
    if (!halted_q) begin
      if (ring_state[T1_IDX]) begin
        cw.ep     = 1'b1;
        cw.lm_bar = 1'b0;
      end else if (ring_state[T2_IDX]) begin
        cw.cp     = step_en;
      end else if (ring_state[T3_IDX]) begin
        cw.ce_bar = 1'b0;
        cw.li_bar = 1'b0;
      end else if (instr_in != HLT_OPCODE) begin
        if (ring_state[T4_IDX]) begin
          case (opcode_e'(instr_in))
            OP_LDA, OP_ADD, OP_SUB: begin
              cw.ei_bar = 1'b0;
              cw.lm_bar = 1'b0;
            end
            OP_OUT: begin
              cw.ea     = 1'b1;
              cw.lo_bar = 1'b0;
            end
            default: ;
          endcase
        end else if (ring_state[T5_IDX]) begin
          case (opcode_e'(instr_in))
            OP_LDA: begin
              cw.ce_bar = 1'b0;
              cw.la_bar = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              cw.ce_bar = 1'b0;
              cw.lb_bar = 1'b0;
            end
            default: ;
          endcase
        end else if (ring_state[T6_IDX]) begin
          case (opcode_e'(instr_in))
            OP_ADD, OP_SUB: begin
              cw.eu     = 1'b1;
              cw.la_bar = 1'b0;
              cw.su     = (instr_in == OP_SUB);
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign Cp      = cw.cp;
  assign Ep      = cw.ep;
  assign Lm_bar  = cw.lm_bar;
  assign CE_bar  = cw.ce_bar;
  assign Li_bar  = cw.li_bar;
  assign Ei_bar  = cw.ei_bar;
  assign La_bar  = cw.la_bar;
  assign Ea      = cw.ea;
  assign Su      = cw.su;
  assign Eu      = cw.eu;
  assign Lb_bar  = cw.lb_bar;
  assign Lo_bar  = cw.lo_bar;
  assign t_state = ring_state;
  assign halted  = halted_q;

endmodule : sap1_controller_sequencer
`default_nettype wire
